ex_mem: RTL and testbench
=========================

# ex_mem

Pipeline latch and data-memory request controller between the execute stage and the MEM/WB latch of the 5-stage MIPS datapath. It captures execute results when the hazard unit advances the pipe and issues exactly one dcache request per load/store. It holds that request until `dhit`, captures load data, and raises `mem_busy` so upstream stages stall. It consumes what `id_ex` forwards through the ALU.

## Interface
Parameters: none. Widths come from `cpu_types_pkg`: `word_t` is 32 bits, `regbits_t` is 5 bits.

Ports. `CLK` and `nRST` are module ports. All other signals travel on `ex_mem_if`, modport `exmem`.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `en` in 1: stage advance from the hazard unit.
- `flush` in 1: load a bubble instead of EX data.
- `ex_Instruction` in 32: instruction in EX.
- `ex_npc` in 32: PC+4 of the EX instruction.
- `ex_aluout` in 32: ALU result, used as the memory address for loads/stores.
- `ex_storedat` in 32: forwarded rt value.
- `ex_wsel` in 5: destination register.
- `ex_RegWr`, `ex_MemtoReg`, `ex_MemRd`, `ex_MemWr`, `ex_halt` in 1 each: EX control bits.
- `dhit` in 1: dcache access complete this cycle.
- `dmemload` in 32: read data, valid when `dhit`.
- `dmemREN`, `dmemWEN` out 1 each: dcache request strobes.
- `dmemaddr`, `dmemstore` out 32 each: dcache address and write data.
- `mem_Instruction`, `mem_npc`, `mem_aluout`, `mem_loaddat` out 32 each: latched values for MEM/WB.
- `mem_wsel` out 5: latched destination register.
- `mem_RegWr`, `mem_MemtoReg`, `mem_halt` out 1 each: latched control for MEM/WB.
- `mem_busy` out 1: an outstanding memory request is not yet hit.

## Operation
- Reset: every output 0, FSM in IDLE.
- FSM states:
  - IDLE: no memory op held.
  - REQ: request outstanding.
  - DONE: access finished; result held until the next advance.
- Load event, when `en & !mem_busy`:
  - If `flush`: latch zeros everywhere (bubble), go to IDLE.
  - Otherwise: latch all `ex_*` into `mem_*` and the internal `memrd`/`memwr` bits, and clear `mem_loaddat`.
  - Go to REQ if `ex_MemRd | ex_MemWr`; else go to IDLE.
- `en` during REQ is ignored; the latch holds. The hazard unit must keep `en` low while `mem_busy` is high, but the block does not rely on that.
- REQ:
  - `dmemREN = memrd & !memwr`, `dmemWEN = memwr`.
  - `dmemaddr = mem_aluout`, `dmemstore` = latched store data.
  - `mem_busy = 1`.
  - On `dhit`: if a read, `mem_loaddat <= dmemload`; go to DONE.
- DONE and IDLE: `dmemREN = dmemWEN = 0`, `mem_busy = 0`. The next load event then applies.
- `MemRd & MemWr` together is illegal; the write takes priority and no read is issued.
- `ex_halt` latched with `MemRd`/`MemWr`: the request is suppressed and the FSM goes to IDLE.
- `dhit` in IDLE or DONE is ignored.
- `dmemaddr` and `dmemstore` are driven from the latched values in every state (0 after reset).

## Timing
- Latch outputs update on the edge where the load event is true: one-cycle latency from EX.
- The request strobe appears in the cycle after the load edge. It is decoded from registered state, with no combinational path from `ex_*`.
- `dhit` in cycle N (the first REQ cycle or later): `mem_loaddat` is valid and the strobes and `mem_busy` drop at edge N+1.
- An access with `dhit` in its first REQ cycle stalls the pipe for 1 cycle.
- `flush` and `en` together: flush wins. `flush` without a qualifying `en` is ignored.
- `nRST` asserted mid-REQ: the strobes drop immediately (asynchronous), all state clears, and the request is abandoned.

## Structure
- `cpu_types_pkg` gains `exmem_state_t` with values IDLE, REQ, DONE.
- Signals are bundled in `ex_mem_if`, with modport `exmem` for this block and `tb` for the bench.
- Single module: one `always_ff` for the latch plus FSM, one `always_comb` for the strobes and `mem_busy`. No sub-module.

## Test plan
- Reset then idle:
  - Stimulus: hold `nRST`=0, then release with `en`=0.
  - Required: all outputs 0, `dmemREN`/`dmemWEN` never high.
- ALU op:
  - Stimulus: `en`=1, `ex_aluout`=0x1234, `RegWr`=1, `wsel`=5.
  - Required: next cycle `mem_aluout`=0x1234, `mem_wsel`=5, `mem_busy`=0.
- Load with delayed hit:
  - Stimulus: `MemRd` with `aluout`=0x80; `dhit` 3 cycles later with `dmemload`=0xDEADBEEF.
  - Required: `dmemREN`=1 and `dmemaddr`=0x80 for 3 cycles, then `mem_loaddat`=0xDEADBEEF and `mem_busy`=0.
  - Required: `en` pulses during REQ do not change the latch.
- Store:
  - Stimulus: `MemWr`, `storedat`=0xCAFE, `aluout`=0x40, `dhit` in the first REQ cycle.
  - Required: `dmemWEN` high for exactly 1 cycle, `dmemstore`=0xCAFE, `dmemREN`=0.
- Flush priority:
  - Stimulus: `en`=`flush`=1 with `MemRd`=1.
  - Required: bubble latched, FSM in IDLE, no request.
- Reset mid-request:
  - Stimulus: drop `nRST` during REQ.
  - Required: strobes fall the same cycle, all outputs 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared widths, types and EX/MEM latch payload for the 5-stage MIPS datapath.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } exmem_state_t;

    // Everything the EX/MEM latch captures from EX on an advance.
    typedef struct packed {
        word_t    instr;
        word_t    npc;
        word_t    aluout;
        word_t    storedat;
        regbits_t wsel;
        logic     regwr;
        logic     memtoreg;
        logic     halt;
        logic     memrd;
        logic     memwr;
    } exmem_lat_t;

endpackage

// File: rtl/ex_mem_if.sv
// Signal bundle between EX, the EX/MEM latch, the dcache port and MEM/WB.
interface ex_mem_if;
    import cpu_types_pkg::*;

    logic     en;
    logic     flush;
    word_t    ex_Instruction;
    word_t    ex_npc;
    word_t    ex_aluout;
    word_t    ex_storedat;
    regbits_t ex_wsel;
    logic     ex_RegWr;
    logic     ex_MemtoReg;
    logic     ex_MemRd;
    logic     ex_MemWr;
    logic     ex_halt;
    logic     dhit;
    word_t    dmemload;
    logic     dmemREN;
    logic     dmemWEN;
    word_t    dmemaddr;
    word_t    dmemstore;
    word_t    mem_Instruction;
    word_t    mem_npc;
    word_t    mem_aluout;
    word_t    mem_loaddat;
    regbits_t mem_wsel;
    logic     mem_RegWr;
    logic     mem_MemtoReg;
    logic     mem_halt;
    logic     mem_busy;

    modport exmem (
        input  en, flush, ex_Instruction, ex_npc, ex_aluout, ex_storedat, ex_wsel,
               ex_RegWr, ex_MemtoReg, ex_MemRd, ex_MemWr, ex_halt, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_Instruction, mem_npc,
               mem_aluout, mem_loaddat, mem_wsel, mem_RegWr, mem_MemtoReg, mem_halt,
               mem_busy
    );

    modport tb (
        output en, flush, ex_Instruction, ex_npc, ex_aluout, ex_storedat, ex_wsel,
               ex_RegWr, ex_MemtoReg, ex_MemRd, ex_MemWr, ex_halt, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_Instruction, mem_npc,
               mem_aluout, mem_loaddat, mem_wsel, mem_RegWr, mem_MemtoReg, mem_halt,
               mem_busy
    );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline latch with a one-request-per-access dcache controller.
// Holds the latch and stalls upstream via mem_busy until the access hits.
module ex_mem
    import cpu_types_pkg::*;
(
    input  logic    CLK,
    input  logic    nRST,
    ex_mem_if.exmem exif
);

    exmem_state_t state, state_n;
    exmem_lat_t   lat;
    word_t        loaddat;
    logic         load_ev_c;
    logic         ren_c;
    logic         wen_c;
    logic         busy_c;
    logic         start_req_c;

    // Halted instructions never reach the dcache; write wins over read.
    assign start_req_c = (exif.ex_MemRd | exif.ex_MemWr) & ~exif.ex_halt;

    // Next state, request strobes and stall, all decoded from registered state.
    always_comb begin
        state_n   = state;
        load_ev_c = 1'b0;
        ren_c     = 1'b0;
        wen_c     = 1'b0;
        busy_c    = 1'b0;
        case (state)
            REQ: begin
                busy_c = 1'b1;
                wen_c  = lat.memwr;
                ren_c  = lat.memrd & ~lat.memwr;
                if (exif.dhit) begin
                    state_n = DONE;
                end
            end
            default: begin
                load_ev_c = exif.en;
                if (exif.en) begin
                    if (exif.flush) begin
                        state_n = IDLE;
                    end else if (start_req_c) begin
                        state_n = REQ;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end

    // Latch capture, load-data capture and FSM state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            lat     <= '0;
            loaddat <= '0;
        end else begin
            state <= state_n;
            if (load_ev_c) begin
                loaddat <= '0;
                if (exif.flush) begin
                    lat <= '0;
                end else begin
                    lat <= '{instr:    exif.ex_Instruction,
                             npc:      exif.ex_npc,
                             aluout:   exif.ex_aluout,
                             storedat: exif.ex_storedat,
                             wsel:     exif.ex_wsel,
                             regwr:    exif.ex_RegWr,
                             memtoreg: exif.ex_MemtoReg,
                             halt:     exif.ex_halt,
                             memrd:    exif.ex_MemRd,
                             memwr:    exif.ex_MemWr};
                end
            end else if ((state == REQ) && exif.dhit && lat.memrd && !lat.memwr) begin
                loaddat <= exif.dmemload;
            end
        end
    end

    assign exif.dmemREN         = ren_c;
    assign exif.dmemWEN         = wen_c;
    assign exif.mem_busy        = busy_c;
    assign exif.dmemaddr        = lat.aluout;
    assign exif.dmemstore       = lat.storedat;
    assign exif.mem_Instruction = lat.instr;
    assign exif.mem_npc         = lat.npc;
    assign exif.mem_aluout      = lat.aluout;
    assign exif.mem_loaddat     = loaddat;
    assign exif.mem_wsel        = lat.wsel;
    assign exif.mem_RegWr       = lat.regwr;
    assign exif.mem_MemtoReg    = lat.memtoreg;
    assign exif.mem_halt        = lat.halt;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed scenarios with literal expectations plus random
// traffic checked every cycle against a transaction-level model.
module tb_ex_mem;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ex_mem_if bus();

    ex_mem dut (
        .CLK  (CLK),
        .nRST (nRST),
        .exif (bus.exmem)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: the latched instruction record plus whether an access is pending.
    bit [31:0] m_instr, m_npc, m_alu, m_store, m_load;
    bit [4:0]  m_wsel;
    bit        m_regwr, m_memtoreg, m_halt;
    bit        pending, pending_is_wr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            {m_instr, m_npc, m_alu, m_store, m_load} = '0;
            m_wsel = '0;
            {m_regwr, m_memtoreg, m_halt, pending, pending_is_wr} = '0;
        end else if (pending) begin
            if (bus.dhit) begin
                if (!pending_is_wr) m_load = bus.dmemload;
                pending = 1'b0;
            end
        end else if (bus.en) begin
            m_load = '0;
            if (bus.flush) begin
                {m_instr, m_npc, m_alu, m_store} = '0;
                m_wsel = '0;
                {m_regwr, m_memtoreg, m_halt, pending_is_wr} = '0;
            end else begin
                m_instr       = bus.ex_Instruction;
                m_npc         = bus.ex_npc;
                m_alu         = bus.ex_aluout;
                m_store       = bus.ex_storedat;
                m_wsel        = bus.ex_wsel;
                m_regwr       = bus.ex_RegWr;
                m_memtoreg    = bus.ex_MemtoReg;
                m_halt        = bus.ex_halt;
                pending       = (bus.ex_MemRd | bus.ex_MemWr) & ~bus.ex_halt;
                pending_is_wr = bus.ex_MemWr;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        chk1("REN",      bus.dmemREN,      pending & ~pending_is_wr);
        chk1("WEN",      bus.dmemWEN,      pending & pending_is_wr);
        chk1("busy",     bus.mem_busy,     pending);
        chk ("addr",     bus.dmemaddr,     m_alu);
        chk ("store",    bus.dmemstore,    m_store);
        chk ("instr",    bus.mem_Instruction, m_instr);
        chk ("npc",      bus.mem_npc,      m_npc);
        chk ("aluout",   bus.mem_aluout,   m_alu);
        chk ("loaddat",  bus.mem_loaddat,  m_load);
        chk ("wsel",     32'(bus.mem_wsel), 32'(m_wsel));
        chk1("RegWr",    bus.mem_RegWr,    m_regwr);
        chk1("MemtoReg", bus.mem_MemtoReg, m_memtoreg);
        chk1("halt",     bus.mem_halt,     m_halt);
    end

    task automatic clr_inputs();
        bus.en = 1'b0; bus.flush = 1'b0; bus.dhit = 1'b0; bus.dmemload = '0;
        bus.ex_Instruction = '0; bus.ex_npc = '0; bus.ex_aluout = '0;
        bus.ex_storedat = '0; bus.ex_wsel = '0; bus.ex_RegWr = 1'b0;
        bus.ex_MemtoReg = 1'b0; bus.ex_MemRd = 1'b0; bus.ex_MemWr = 1'b0;
        bus.ex_halt = 1'b0;
    endtask

    // Advance one edge; afterwards inputs may be changed safely.
    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    initial begin
        clr_inputs();
        nRST = 1'b0;
        cycle(); cycle();
        chk ("rst aluout", bus.mem_aluout, 32'h0);
        chk1("rst busy",   bus.mem_busy,   1'b0);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk1("idle REN", bus.dmemREN, 1'b0);
            chk1("idle WEN", bus.dmemWEN, 1'b0);
        end

        // ALU op
        bus.en = 1'b1; bus.ex_aluout = 32'h1234; bus.ex_RegWr = 1'b1; bus.ex_wsel = 5'd5;
        cycle();
        chk ("alu aluout", bus.mem_aluout, 32'h1234);
        chk ("alu wsel",   32'(bus.mem_wsel), 32'd5);
        chk1("alu busy",   bus.mem_busy, 1'b0);

        // Load, hit in the third REQ cycle, en pulses ignored meanwhile
        clr_inputs();
        bus.en = 1'b1; bus.ex_MemRd = 1'b1; bus.ex_MemtoReg = 1'b1; bus.ex_RegWr = 1'b1;
        bus.ex_aluout = 32'h80;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk1("ld REN",  bus.dmemREN,  1'b1);
            chk ("ld addr", bus.dmemaddr, 32'h80);
            chk1("ld busy", bus.mem_busy, 1'b1);
            bus.en = (i != 1); bus.ex_aluout = 32'h999; bus.ex_MemRd = 1'b0;
            bus.dhit = (i == 2); bus.dmemload = 32'hDEADBEEF;
            cycle();
        end
        chk ("ld data",  bus.mem_loaddat, 32'hDEADBEEF);
        chk1("ld busy0", bus.mem_busy,    1'b0);
        chk1("ld REN0",  bus.dmemREN,     1'b0);
        chk ("ld hold",  bus.mem_aluout,  32'h80);

        // Store with immediate hit
        clr_inputs();
        bus.en = 1'b1; bus.ex_MemWr = 1'b1; bus.ex_storedat = 32'hCAFE; bus.ex_aluout = 32'h40;
        cycle();
        chk1("st WEN",   bus.dmemWEN,   1'b1);
        chk1("st REN",   bus.dmemREN,   1'b0);
        chk ("st data",  bus.dmemstore, 32'hCAFE);
        chk ("st addr",  bus.dmemaddr,  32'h40);
        clr_inputs();
        bus.dhit = 1'b1;
        cycle();
        bus.dhit = 1'b0;
        chk1("st WEN0",  bus.dmemWEN,   1'b0);
        chk1("st busy0", bus.mem_busy,  1'b0);

        // Flush beats en
        bus.en = 1'b1; bus.flush = 1'b1; bus.ex_MemRd = 1'b1; bus.ex_aluout = 32'h77;
        bus.ex_RegWr = 1'b1;
        cycle();
        chk1("fl REN",   bus.dmemREN,    1'b0);
        chk1("fl busy",  bus.mem_busy,   1'b0);
        chk ("fl alu",   bus.mem_aluout, 32'h0);
        chk1("fl RegWr", bus.mem_RegWr,  1'b0);

        // Halt suppresses the request; read+write issues only the write
        clr_inputs();
        bus.en = 1'b1; bus.ex_MemRd = 1'b1; bus.ex_halt = 1'b1;
        cycle();
        chk1("hl busy", bus.mem_busy, 1'b0);
        chk1("hl halt", bus.mem_halt, 1'b1);
        clr_inputs();
        bus.en = 1'b1; bus.ex_MemRd = 1'b1; bus.ex_MemWr = 1'b1;
        cycle();
        chk1("rw WEN", bus.dmemWEN, 1'b1);
        chk1("rw REN", bus.dmemREN, 1'b0);
        clr_inputs();
        bus.dhit = 1'b1;
        cycle();
        clr_inputs();

        // Reset in the middle of a request
        bus.en = 1'b1; bus.ex_MemRd = 1'b1; bus.ex_aluout = 32'h100;
        cycle();
        chk1("mr REN", bus.dmemREN, 1'b1);
        clr_inputs();
        #1 nRST = 1'b0;
        #1;
        chk1("mr REN0",  bus.dmemREN,    1'b0);
        chk1("mr busy0", bus.mem_busy,   1'b0);
        chk ("mr alu0",  bus.mem_aluout, 32'h0);
        cycle();
        nRST = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.en             = ($urandom_range(0, 3) != 0);
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.dhit           = ($urandom_range(0, 4) < 2);
            bus.dmemload       = $urandom;
            bus.ex_Instruction = $urandom;
            bus.ex_npc         = $urandom;
            bus.ex_aluout      = $urandom;
            bus.ex_storedat    = $urandom;
            bus.ex_wsel        = 5'($urandom);
            bus.ex_RegWr       = 1'($urandom);
            bus.ex_MemtoReg    = 1'($urandom);
            bus.ex_MemRd       = 1'($urandom);
            bus.ex_MemWr       = ($urandom_range(0, 2) == 0);
            bus.ex_halt        = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 nRST = 1'b0;
                #1 nRST = 1'b1;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
